xgmii_frame_checker: RTL

Parametrised successor to the 64-bit MII checker. Monitors a generator-driven XGMII/CGMII-style bus of DATA_WIDTH/8 byte lanes with per-lane control bits, and tracks frame boundaries lane-by-lane. Classifies protocol violations and keeps saturating good/bad frame, byte and error counters. Sits beside the generator in the MII benches and in-system as a link monitor.

---
 rtl/mii_pkg.sv | 35 +++
 rtl/mii_lane_classifier.sv | 23 ++
 rtl/xgmii_frame_checker.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mii_pkg.sv
// Shared definitions for the MII/XGMII monitors: control characters, error flag
// positions and the per-lane character classes produced by the lane classifier.
package mii_pkg;

  localparam logic [7:0] CH_IDLE  = 8'h07;
  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;
  localparam logic [7:0] CH_ERROR = 8'hFE;

  localparam int ERR_BITS = 7;

  typedef enum logic [2:0] {
    ERR_UNEXP_START      = 3'd0,
    ERR_UNEXP_TERM       = 3'd1,
    ERR_DATA_OUTSIDE     = 3'd2,
    ERR_INVALID_CTRL     = 3'd3,
    ERR_ERR_CHAR         = 3'd4,
    ERR_MISALIGNED_START = 3'd5,
    ERR_RUNT_OR_LONG     = 3'd6
  } err_bit_e;

  typedef enum logic [2:0] {
    LC_DATA,
    LC_IDLE,
    LC_START,
    LC_TERM,
    LC_ERROR,
    LC_INVALID
  } lane_class_t;

  function automatic int lanes_of(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mii_lane_classifier.sv
// Maps one byte lane (data byte plus control bit) onto a character class.
module mii_lane_classifier
  import mii_pkg::*;
(
  input  logic [7:0]  data,
  input  logic        ctrl,
  output lane_class_t cls
);

  always_comb begin
    cls = LC_DATA;
    if (ctrl) begin
      case (data)
        CH_IDLE:  cls = LC_IDLE;
        CH_START: cls = LC_START;
        CH_TERM:  cls = LC_TERM;
        CH_ERROR: cls = LC_ERROR;
        default:  cls = LC_INVALID;
      endcase
    end
  end

endmodule

// File: rtl/xgmii_frame_checker.sv
// Lane-by-lane XGMII frame monitor: tracks frame boundaries, classifies protocol
// violations and keeps saturating frame, byte and error statistics.
module xgmii_frame_checker
  import mii_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int CNT_WIDTH       = 32,
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_monitoring,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] ctrl_in,
  output logic                    in_frame,
  output logic [CNT_WIDTH-1:0]    good_frame_cnt,
  output logic [CNT_WIDTH-1:0]    bad_frame_cnt,
  output logic [CNT_WIDTH-1:0]    byte_cnt,
  output logic [CNT_WIDTH-1:0]    err_cnt,
  output logic [ERR_BITS-1:0]     err_flags,
  output logic                    err_pulse,
  output logic [15:0]             last_len,
  output logic                    report_valid
);

  localparam int LANES = lanes_of(DATA_WIDTH);
  localparam int LEN_W = 16;
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_FRAME_BYTES);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FRAME_BYTES);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_FRAME_BYTES + 1);

  typedef enum logic {
    TRK_IDLE,
    TRK_FRAME
  } trk_state_t;

  trk_state_t        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              bad_q, bad_d;
  logic [15:0]       last_len_d;
  logic [15:0]       good_inc, bad_inc, byte_inc;
  logic [ERR_BITS-1:0] err_ev;
  logic              mon_q;

  lane_class_t lane_cls [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mii_lane_classifier u_cls (
      .data (data_in[8*g +: 8]),
      .ctrl (ctrl_in[g]),
      .cls  (lane_cls[g])
    );
  end

  // Adds an increment and clamps at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [15:0] b);
    logic [CNT_WIDTH+16:0] s;
    s = {17'd0, a} + {{(CNT_WIDTH+1){1'b0}}, b};
    if (s[CNT_WIDTH+16:CNT_WIDTH] != '0) return '1;
    return s[CNT_WIDTH-1:0];
  endfunction

  // The tracker walks the lanes in wire order within one cycle, so the running
  // state carries across lanes and several frames may open or close per word.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    bad_d      = bad_q;
    last_len_d = last_len;
    good_inc   = '0;
    bad_inc    = '0;
    byte_inc   = '0;
    err_ev     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_cls[i] == LC_START && (i % 4) != 0) err_ev[ERR_MISALIGNED_START] = 1'b1;
      case (state_d)
        TRK_IDLE: begin
          case (lane_cls[i])
            LC_START: begin
              state_d = TRK_FRAME;
              len_d   = '0;
              bad_d   = 1'b0;
            end
            LC_TERM:    err_ev[ERR_UNEXP_TERM]   = 1'b1;
            LC_DATA:    err_ev[ERR_DATA_OUTSIDE] = 1'b1;
            LC_ERROR:   err_ev[ERR_ERR_CHAR]     = 1'b1;
            LC_INVALID: err_ev[ERR_INVALID_CTRL] = 1'b1;
            default: ;
          endcase
        end
        TRK_FRAME: begin
          case (lane_cls[i])
            LC_DATA: begin
              if (len_d != LEN_SAT) len_d = len_d + 16'd1;
            end
            LC_TERM: begin
              last_len_d = len_d;
              if (len_d < LEN_MIN || len_d > LEN_MAX) err_ev[ERR_RUNT_OR_LONG] = 1'b1;
              if (!bad_d && len_d >= LEN_MIN && len_d <= LEN_MAX) begin
                good_inc = good_inc + 16'd1;
                byte_inc = byte_inc + len_d;
              end else begin
                bad_inc = bad_inc + 16'd1;
              end
              state_d = TRK_IDLE;
            end
            LC_START: begin
              err_ev[ERR_UNEXP_START] = 1'b1;
              bad_inc    = bad_inc + 16'd1;
              last_len_d = len_d;
              len_d      = '0;
              bad_d      = 1'b0;
            end
            LC_ERROR: begin
              err_ev[ERR_ERR_CHAR] = 1'b1;
              bad_d = 1'b1;
            end
            default: begin
              err_ev[ERR_INVALID_CTRL] = 1'b1;
              bad_inc    = bad_inc + 16'd1;
              last_len_d = len_d;
              state_d    = TRK_IDLE;
            end
          endcase
        end
        default: state_d = TRK_IDLE;
      endcase
    end
  end

  // Tracking and last_len always advance; statistics only while monitoring.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= TRK_IDLE;
      len_q          <= '0;
      bad_q          <= 1'b0;
      last_len       <= '0;
      mon_q          <= 1'b0;
      report_valid   <= 1'b0;
      good_frame_cnt <= '0;
      bad_frame_cnt  <= '0;
      byte_cnt       <= '0;
      err_cnt        <= '0;
      err_flags      <= '0;
      err_pulse      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      bad_q        <= bad_d;
      last_len     <= last_len_d;
      mon_q        <= start_monitoring;
      report_valid <= mon_q & ~start_monitoring;
      if (start_monitoring) begin
        good_frame_cnt <= sat_add(good_frame_cnt, good_inc);
        bad_frame_cnt  <= sat_add(bad_frame_cnt, bad_inc);
        byte_cnt       <= sat_add(byte_cnt, byte_inc);
        err_cnt        <= sat_add(err_cnt, {15'd0, |err_ev});
        err_flags      <= err_flags | err_ev;
        err_pulse      <= |err_ev;
      end else begin
        err_pulse <= 1'b0;
      end
    end
  end

  assign in_frame = (state_q == TRK_FRAME);

endmodule
